// File: rtl/rtype_exec.sv
// rtype_exec: four-state MIPS R-type executor (capture, register read, execute, write back).
module rtype_exec (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Inst_Valid,
  input  logic [31:0] Inst,
  output logic        Inst_Ready,
  output logic [4:0]  R_Addr_A,
  output logic [4:0]  R_Addr_B,
  input  logic [31:0] R_Data_A,
  input  logic [31:0] R_Data_B,
  output logic [4:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic        Write_reg,
  output logic        Done,
  output logic        Zero,
  output logic        Overflow,
  output logic        Illegal
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  state_t state, state_nxt;
  logic [31:0] inst_q, a_q, b_q, res, sum, dif;
  logic [4:0] shamt;
  logic ovf, ill;
  assign R_Addr_A = inst_q[25:21];
  assign R_Addr_B = inst_q[20:16];
  assign W_Addr = inst_q[15:11];
  assign shamt = inst_q[10:6];
  assign sum = a_q + b_q;
  assign dif = a_q - b_q;
  assign Inst_Ready = state == IDLE;
  assign Done = state == WB;
  assign Write_reg = Done && !Illegal && !Overflow && W_Addr != 5'd0;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = Inst_Valid ? READ : IDLE;
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    res = '0;
    ovf = 1'b0;
    ill = inst_q[31:26] != 6'd0;
    case (inst_q[5:0])
      6'b100000: begin
        res = sum;
        ovf = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
      end
      6'b100010: begin
        res = dif;
        ovf = (a_q[31] != b_q[31]) && (dif[31] != a_q[31]);
      end
      6'b100100: res = a_q & b_q;
      6'b100101: res = a_q | b_q;
      6'b100110: res = a_q ^ b_q;
      6'b100111: res = ~(a_q | b_q);
      6'b101010: res = {31'd0, $signed(a_q) < $signed(b_q)};
      6'b101011: res = {31'd0, a_q < b_q};
      6'b000000: res = b_q << shamt;
      6'b000010: res = b_q >> shamt;
      6'b000011: res = $signed(b_q) >>> shamt;
      default: ill = 1'b1;
    endcase
    ovf = ovf && !ill;
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      inst_q <= '0;
      a_q <= '0;
      b_q <= '0;
      W_Data <= '0;
      Zero <= 1'b0;
      Overflow <= 1'b0;
      Illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && Inst_Valid) inst_q <= Inst;
      if (state == READ) begin
        a_q <= R_Data_A;
        b_q <= R_Data_B;
      end
      // illegal instructions keep the previous write data on the bus
      if (state == EXEC) begin
        if (!ill) W_Data <= res;
        Zero <= !ill && res == 32'd0;
        Overflow <= ovf;
        Illegal <= ill;
      end
    end
  end
endmodule

// File: tb/tb_rtype_exec.sv
// tb_rtype_exec: directed-vector bench for rtype_exec with a static register-file model.
module tb_rtype_exec;
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Inst_Valid = 1'b0;
  logic [31:0] Inst = '0;
  logic        Inst_Ready;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic [31:0] R_Data_A, R_Data_B, W_Data;
  logic        Write_reg, Done, Zero, Overflow, Illegal;
  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  rtype_exec dut (
    .Clk(Clk), .Reset(Reset), .Inst_Valid(Inst_Valid), .Inst(Inst), .Inst_Ready(Inst_Ready),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_reg(Write_reg), .Done(Done),
    .Zero(Zero), .Overflow(Overflow), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;
  assign R_Data_A = rf[R_Addr_A];
  assign R_Data_B = rf[R_Addr_B];

  always @(posedge Clk) begin
    if (Write_reg) wr_cnt++;
    if (Done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] wd, input logic wr,
                     input logic z, input logic o, input logic il, input logic hold);
    @(negedge Clk);
    Inst = ins;
    Inst_Valid = 1'b1;
    @(posedge Clk);
    #1 if (!hold) Inst_Valid = 1'b0;
    @(negedge Clk);
    chk({tag, ".read_rdy"}, Inst_Ready, 0);
    chk({tag, ".ra"}, R_Addr_A, ins[25:21]);
    chk({tag, ".rb"}, R_Addr_B, ins[20:16]);
    if (hold) Inst = enc(6'd0, 5'd31, 5'd30, 5'd29, 5'd0, 6'b100000);
    @(negedge Clk);
    chk({tag, ".exec_done"}, Done, 0);
    chk({tag, ".exec_rdy"}, Inst_Ready, 0);
    @(negedge Clk);
    chk({tag, ".done"}, Done, 1);
    chk({tag, ".wreg"}, Write_reg, wr);
    chk({tag, ".wdata"}, W_Data, wd);
    chk({tag, ".waddr"}, W_Addr, ins[15:11]);
    chk({tag, ".ra_wb"}, R_Addr_A, ins[25:21]);
    chk({tag, ".zero"}, Zero, z);
    chk({tag, ".ovf"}, Overflow, o);
    chk({tag, ".ill"}, Illegal, il);
    @(negedge Clk);
    chk({tag, ".idle_rdy"}, Inst_Ready, 1);
    chk({tag, ".idle_done"}, Done, 0);
    chk({tag, ".flag_hold"}, {29'd0, Zero, Overflow, Illegal}, {29'd0, z, o, il});
    Inst_Valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    rf[4] = 32'h7FFFFFFF;
    rf[5] = 32'd1;
    rf[6] = 32'hFFFFFFFF;
    rf[7] = 32'h80000000;
    #12;
    chk("rst.rdy", Inst_Ready, 1);
    chk("rst.wreg", Write_reg, 0);
    chk("rst.done", Done, 0);
    chk("rst.wdata", W_Data, 0);
    chk("rst.flags", {29'd0, Zero, Overflow, Illegal}, 0);
    chk("rst.addr", {17'd0, R_Addr_A, R_Addr_B, W_Addr}, 0);
    @(negedge Clk);
    Reset = 1'b1;
    run("add",     enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'd12,         1, 0, 0, 0, 0);
    run("add_ovf", enc(6'd0, 5'd4, 5'd5, 5'd9, 5'd0, 6'b100000), 32'h80000000,   0, 0, 1, 0, 0);
    run("slt",     enc(6'd0, 5'd6, 5'd5, 5'd10, 5'd0, 6'b101010), 32'd1,         1, 0, 0, 0, 0);
    run("sltu",    enc(6'd0, 5'd6, 5'd5, 5'd11, 5'd0, 6'b101011), 32'd0,         1, 1, 0, 0, 0);
    run("sra",     enc(6'd0, 5'd0, 5'd7, 5'd12, 5'd4, 6'b000011), 32'hF8000000,  1, 0, 0, 0, 0);
    run("ill_fn",  enc(6'd0, 5'd1, 5'd2, 5'd13, 5'd0, 6'b111111), 32'hF8000000,  0, 0, 0, 1, 0);
    run("ill_op",  enc(6'h08, 5'd4, 5'd5, 5'd14, 5'd0, 6'b100000), 32'hF8000000, 0, 0, 0, 1, 0);
    run("and",     enc(6'd0, 5'd1, 5'd2, 5'd15, 5'd0, 6'b100100), 32'd5,         1, 0, 0, 0, 0);
    run("or",      enc(6'd0, 5'd1, 5'd2, 5'd16, 5'd0, 6'b100101), 32'd7,         1, 0, 0, 0, 0);
    run("xor",     enc(6'd0, 5'd1, 5'd2, 5'd17, 5'd0, 6'b100110), 32'd2,         1, 0, 0, 0, 0);
    run("nor",     enc(6'd0, 5'd1, 5'd2, 5'd18, 5'd0, 6'b100111), 32'hFFFFFFF8,  1, 0, 0, 0, 0);
    run("sll",     enc(6'd0, 5'd0, 5'd5, 5'd19, 5'd31, 6'b000000), 32'h80000000, 1, 0, 0, 0, 0);
    run("srl",     enc(6'd0, 5'd0, 5'd7, 5'd20, 5'd4, 6'b000010), 32'h08000000,  1, 0, 0, 0, 0);
    run("sub_ovf", enc(6'd0, 5'd7, 5'd5, 5'd21, 5'd0, 6'b100010), 32'h7FFFFFFF,  0, 0, 1, 0, 0);
    run("sub_rd0", enc(6'd0, 5'd1, 5'd1, 5'd0, 5'd0, 6'b100010), 32'd0,          0, 1, 0, 0, 1);
    @(negedge Clk);
    Inst = enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000);
    Inst_Valid = 1'b1;
    @(posedge Clk);
    #1 Inst_Valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("abort.in_exec", Inst_Ready, 0);
    #2 Reset = 1'b0;
    #1;
    chk("abort.rdy", Inst_Ready, 1);
    chk("abort.wreg", Write_reg, 0);
    chk("abort.done", Done, 0);
    chk("abort.wdata", W_Data, 0);
    chk("abort.flags", {29'd0, Zero, Overflow, Illegal}, 0);
    chk("abort.addr", {17'd0, R_Addr_A, R_Addr_B, W_Addr}, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("abort.held", Done, 0);
    Reset = 1'b1;
    run("add_again", enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'd12, 1, 0, 0, 0, 0);
    repeat (2) @(negedge Clk);
    chk("total.writes", wr_cnt, 11);
    chk("total.dones", done_cnt, 16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rtype_exec.md
RTYPE_EXEC -- requirements
Module: rtype_exec

Interface
REQ-001 The block SHALL have one parameter: none; all widths are fixed at 32-bit data and 5-bit register addresses.
REQ-002 Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; Reset=0 forces the reset state immediately, independent of Clk.
REQ-004 Inst_Valid  input  1  an instruction is offered on Inst.
REQ-005 Inst  input  32  MIPS R-type word: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
REQ-006 Inst_Ready  output  1  block can accept an instruction.
REQ-007 R_Addr_A  output  5  register-file read port A address (rs).
REQ-008 R_Addr_B  output  5  register-file read port B address (rt).
REQ-009 R_Data_A  input  32  register-file read data A; combinational from R_Addr_A.
REQ-010 R_Data_B  input  32  register-file read data B; combinational from R_Addr_B.
REQ-011 W_Addr  output  5  register-file write address (rd).
REQ-012 W_Data  output  32  register-file write data.
REQ-013 Write_reg  output  1  register-file write enable; the write happens on the Clk edge that ends the high cycle.
REQ-014 Done  output  1  one-cycle pulse marking instruction retirement.
REQ-015 Zero, Overflow, Illegal  output  1 each  status flags of the last executed instruction.

Function
REQ-016 The FSM SHALL have four states: IDLE, READ, EXEC and WB, with Inst_Ready=1 only in IDLE.
REQ-017 In IDLE, a rising edge with Inst_Valid=1 SHALL capture Inst into an internal register and move the FSM to READ; with Inst_Valid=0 the FSM stays in IDLE.
REQ-018 In READ, the block SHALL drive R_Addr_A=rs and R_Addr_B=rt from the captured word, latch R_Data_A and R_Data_B into operand registers at the edge, and go to EXEC.
REQ-019 In EXEC, the block SHALL compute the result and flags from the operand registers, register them at the edge, and go to WB.
REQ-020 In WB, Done SHALL be 1; Write_reg SHALL be 1 if and only if Illegal=0, Overflow=0 and rd!=0; the FSM then returns to IDLE.
REQ-021 Latency SHALL be fixed: handshake at edge E0, regfile write at E3, Inst_Ready high again after E3, for a throughput of one instruction per 4 cycles.
REQ-022 R_Addr_A, R_Addr_B and W_Addr SHALL hold their values from the captured word (rs, rt, rd) in every state after capture, and SHALL be 0 after reset.
REQ-023 funct decode (valid only when op=0):
- 100000 ADD: A+B, signed overflow detected.
- 100010 SUB: A-B, signed overflow detected.
- 100100 AND.
- 100101 OR.
- 100110 XOR.
- 100111 NOR.
- 101010 SLT: signed less-than, result 1 or 0.
- 101011 SLTU: unsigned less-than, result 1 or 0.
- 000000 SLL: B<<shamt.
- 000010 SRL: logical right shift of B by shamt.
- 000011 SRA: arithmetic right shift of B by shamt.
REQ-024 An instruction with op!=0 or any other funct SHALL set Illegal=1, Zero=0 and Overflow=0, and SHALL leave W_Data unchanged.
REQ-025 Overflow SHALL be set only for ADD/SUB when the operand signs make the 32-bit signed result wrap; in that case the write is suppressed but W_Data still shows the wrapped sum.
REQ-026 Zero SHALL equal (result==0) for legal instructions.
REQ-027 Flags SHALL update only at the end of EXEC and hold until the next EXEC.
REQ-028 rd=0 SHALL retire normally (Done=1, flags valid) with Write_reg=0.
REQ-029 Inst_Valid and Inst SHALL be ignored outside IDLE.

Reset
REQ-030 Reset=0 SHALL immediately force IDLE, clear the captured instruction, the operand registers and all outputs (Inst_Ready=1, Write_reg=0, Done=0, W_Data=0, all flags 0), and abandon any in-flight instruction with no write.
REQ-031 After Reset returns to 1, the first acceptance SHALL occur on the first rising edge with Inst_Valid=1.

Verification
REQ-032 ADD, rs=1 (5), rt=2 (7), rd=3 -> Write_reg=1 and W_Addr=3, W_Data=12, Zero=0 in the 3rd cycle after the handshake; Done pulses once.
REQ-033 ADD with 0x7FFFFFFF + 1 -> Overflow=1, Write_reg=0, W_Data=0x80000000, Done=1.
REQ-034 SLT with A=0xFFFFFFFF, B=1 -> result 1; SLTU with the same operands -> result 0; SRA of B=0x80000000 by shamt 4 -> 0xF8000000.
REQ-035 funct=111111 or op=0x08 -> Illegal=1, Write_reg=0, Done=1; SUB with rd=0 and equal operands -> Zero=1, Write_reg=0.
REQ-036 Reset=0 asserted during EXEC -> outputs cleared with no clock edge, no Write_reg pulse, Inst_Ready=1; Inst_Valid held high during READ/EXEC/WB -> no second capture until IDLE.
